axi_rr_txn_arbiter: RTL

AXI_RR_TXN_ARBITER -- requirements
Module: axi_rr_txn_arbiter

---
 rtl/axi_rr_txn_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/axi_rr_txn_arbiter.sv
// Round-robin transaction arbiter: one grant held from issue until
// the granted acknowledge, an optional watchdog release, or reset.
module axi_rr_txn_arbiter #(
  parameter int PORTS          = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CW             = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [CW-1:0]    grant_encoded,
  output logic             timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int TO_LIM_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LIM = TW'(TO_LIM_I);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] last;
  logic [CW-1:0] win_idx;
  logic          win_found;
  logic [TW-1:0] wd_cnt;
  logic          ack_hit;
  logic          wd_fire;

  // Cyclic search starting just past the last granted index.
  always_comb begin
    int idx;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last) + i) % PORTS;
      if (!win_found && request[idx]) begin
        win_found = 1'b1;
        win_idx   = CW'(idx);
      end
    end
  end

  assign ack_hit = (state == BUSY) &&
                   acknowledge[grant_encoded];
  assign wd_fire = WD_EN && (state == BUSY) &&
                   !ack_hit && (wd_cnt == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      timeout       <= 1'b0;
      wd_cnt        <= '0;
      last          <= CW'(PORTS - 1);
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state         <= BUSY;
            grant         <= PORTS'(1) << win_idx;
            grant_valid   <= 1'b1;
            grant_encoded <= win_idx;
            last          <= win_idx;
            wd_cnt        <= '0;
          end
        end
        BUSY: begin
          // Acknowledge wins over a coincident watchdog expiry.
          if (ack_hit || wd_fire) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            timeout       <= wd_fire;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
